mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); SHALL be >= 2.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; SHALL be a power of two, >= 2.
REQ-003 Parameter BASE_ADDR, default 32'h0000_1000, byte address of the register window; bits [2:0] SHALL be zero.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  store strobe from the CPU (MemWrite).
REQ-007 a  input  32  byte address from the CPU (ALUResult).
REQ-008 wd  input  32  store data from the CPU (WriteData).
REQ-009 rd  output  32  combinational read data for the CPU load path.
REQ-010 hit  output  1  combinational; high when a[31:3] == BASE_ADDR[31:3].
REQ-011 tx  output  1  registered serial line, idle high.
REQ-012 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-013 Register map: a[2]=0 is DATA; a[2]=1 is STATUS; a[1:0] SHALL be ignored.
REQ-014 Store with hit & we to DATA SHALL push wd[7:0] into the FIFO on that edge; wd[31:8] SHALL be ignored.
REQ-015 Push with FIFO full and no same-edge pop SHALL be dropped and SHALL set sticky overflow; push with a same-edge pop SHALL be accepted.
REQ-016 Store with hit & we to STATUS with wd[2]=1 SHALL clear overflow; all other STATUS bits are read-only.
REQ-017 Clear and new overflow on the same edge: overflow SHALL end set.
REQ-018 STATUS read: bit0 full, bit1 empty, bit2 overflow, bit3 FSM not IDLE, bits[7:4] FIFO occupancy (saturating at 15), bits[31:8] zero.
REQ-019 DATA read SHALL return zero; rd SHALL be zero when hit is low.
REQ-020 FSM states IDLE, START, DATA, STOP; one bit-timer counting 0..CLKS_PER_BIT-1; one 3-bit bit index.
REQ-021 IDLE: tx=1; if FIFO non-empty, pop head into shift register, clear timer, go START on the same edge.
REQ-022 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-023 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, 8 bits, then STOP.
REQ-024 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; consecutive frames SHALL be separated by exactly one IDLE cycle.
REQ-025 tx SHALL fall one clock after the edge capturing a DATA store into an empty FIFO while IDLE.
REQ-026 Frame length SHALL be 10*CLKS_PER_BIT cycles of non-IDLE state.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH.

Reset
REQ-028 On rst assertion, asynchronously: tx=1, FSM=IDLE, FIFO empty, overflow=0, timer and bit index zero, busy=0.
REQ-029 Reset mid-frame SHALL abort the frame with tx high immediately; queued bytes SHALL be discarded.
REQ-030 First push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Package mmio_uart_pkg SHALL hold the FSM state encoding, DATA/STATUS offsets and STATUS bit positions.
REQ-032 FIFO SHALL be a separate sub-module sync_fifo (push, pop, full, empty, count), instantiated once.
REQ-033 The block SHALL be instantiable beside data_memory in the CPU top, the top muxing rd onto the load path when hit is high.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h1000)
REQ-034 Store 32'hA5 to 32'h1000 -> tx low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; busy falls after the 40-cycle frame.
REQ-035 Five back-to-back stores (32'h01..32'h05) while frame active -> STATUS reads bit0=1, bit2=1; bytes 01..04 sent in order, one IDLE cycle between frames; 05 lost.
REQ-036 Store 32'h4 to 32'h1004 after overflow -> STATUS bit2 reads 0 next cycle; other bits unchanged.
REQ-037 Assert rst during DATA bit 3 of a frame with two bytes queued -> tx=1 immediately, STATUS reads 32'h2 after release, no further frames.
REQ-038 Load from 32'h2000 with we=1 -> hit=0, rd=0, FIFO unchanged, tx stays high.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the FSM state encoding, the register offsets inside the 8-byte
// window, the STATUS bit layout and a small occupancy helper.
package mmio_uart_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;

  // The register window is 8 bytes: a[31:3] selects the window.
  localparam int unsigned WIN_LSB     = 3;
  // a[2] selects DATA or STATUS; a[1:0] are don't-care.
  localparam int unsigned REG_SEL_BIT = 2;
  localparam logic [2:0]  OFS_DATA    = 3'h0;
  localparam logic [2:0]  OFS_STATUS  = 3'h4;

  // STATUS word layout (bits [31:8] read as zero).
  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_BUSY_BIT  = 3;
  localparam int unsigned STAT_OCC_LSB   = 4;
  localparam int unsigned STAT_OCC_W     = 4;

  // Writing a 1 to this STATUS bit clears the sticky overflow flag.
  localparam int unsigned CLR_OVF_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Occupancy as reported in STATUS, saturating at 15.
  function automatic logic [STAT_OCC_W-1:0] sat_occ(input logic [31:0] count);
    if (count > 32'd15) begin
      return 4'hF;
    end
    return count[STAT_OCC_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata - write request and data; accepted when not full or when a
//                pop happens on the same edge
//   pop        - read request; ignored while empty
//   rdata      - head entry (valid while !empty)
//   full/empty - occupancy flags
//   count      - occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop && !w_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_push = push && (!w_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Sits beside data memory on the CPU store/load path; the CPU top muxes
// rd onto the load path whenever hit is high.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   we, a, wd - CPU store strobe, byte address, store data
//   rd       - combinational read data (zero unless hit)
//   hit      - combinational window decode, a[31:3] == BASE_ADDR[31:3]
//   tx       - registered serial line, idle high
//   busy     - frame in progress or bytes queued
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int unsigned       CLKS_PER_BIT = 434,
  parameter int unsigned       FIFO_DEPTH   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              hit,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  // Address decode and CPU request qualification
  logic w_hit;
  logic w_sel_data;
  logic w_sel_status;
  logic w_push_req;
  logic w_clr_req;
  logic w_unused;

  assign w_hit        = (a[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB]);
  assign w_sel_data   = (a[REG_SEL_BIT] == OFS_DATA[REG_SEL_BIT]);
  assign w_sel_status = (a[REG_SEL_BIT] == OFS_STATUS[REG_SEL_BIT]);
  assign w_push_req   = w_hit && we && w_sel_data;
  assign w_clr_req    = w_hit && we && w_sel_status && wd[CLR_OVF_BIT];
  assign w_unused     = &{1'b0, a[1:0], wd[DATA_W-1:BYTE_W]};

  // Transmit FIFO
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [BYTE_W-1:0] w_head;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .wdata (wd[BYTE_W-1:0]),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Sticky overflow: a new drop wins over a clear on the same edge.
  logic w_ovf_set;
  logic r_ovf;

  assign w_ovf_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_clr_req) begin
      r_ovf <= 1'b0;
    end
  end

  // Serializer state
  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_tmr_done;

  assign w_tmr_done = (r_timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // tx is computed for the next state so the line changes on the same
  // edge as the state, keeping every bit exactly CLKS_PER_BIT cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_timer_nxt   = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_START;
          w_tx_nxt      = 1'b0;
        end
      end

      ST_START: begin
        if (w_tmr_done) begin
          w_timer_nxt   = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      ST_DATA: begin
        if (w_tmr_done) begin
          w_timer_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[BYTE_W-1:1]};
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tmr_done) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // STATUS word and read mux
  logic [31:0]       w_count32;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd;

  assign w_count32 = 32'(w_count);

  always_comb begin
    w_status                              = '0;
    w_status[STAT_FULL_BIT]               = w_full;
    w_status[STAT_EMPTY_BIT]              = w_empty;
    w_status[STAT_OVF_BIT]                = r_ovf;
    w_status[STAT_BUSY_BIT]               = (r_state != ST_IDLE);
    w_status[STAT_OCC_LSB +: STAT_OCC_W]  = sat_occ(w_count32);
  end

  always_comb begin
    w_rd = '0;
    if (w_hit && w_sel_status) begin
      w_rd = w_status;
    end
  end

  assign rd   = w_rd;
  assign hit  = w_hit;
  assign tx   = r_tx;
  assign busy = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A serial monitor decodes every frame on tx and compares it with the
// bytes queued when the stores were driven.
module tb_mmio_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst;
  logic        we = 1'b0;
  logic [31:0] a  = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        hit;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .hit  (hit),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected bytes and start-bit sample times
  logic [7:0] sb_q[$];
  int         start_q[$];
  int         cyc = 0;

  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = '0;
  logic       prev_tx    = 1'b1;

  // Serial monitor: samples once per clock, mid-bit for each field.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == C / 2) begin
        check("start_bit", 32'(tx), 32'd0);
      end else if (mon_cnt >= C + C / 2 && mon_cnt < 9 * C &&
                   ((mon_cnt - C - C / 2) % C) == 0) begin
        mon_byte = {tx, mon_byte[7:1]};
      end else if (mon_cnt == 9 * C + C / 2) begin
        check("stop_bit", 32'(tx), 32'd1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got byte %h expected no frame", mon_byte);
        end else begin
          check("rx_byte", 32'(mon_byte), 32'(sb_q.pop_front()));
        end
        mon_active = 1'b0;
      end
    end
    prev_tx = tx;
  end

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] byte_v;
  logic [31:0] exp_v;
  logic       found;
  logic       saw_low;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 1'b0, 32'h0,         1'b1, 32'h0, 32'h2};
    vecs[1] = '{32'h0000_1004, 1'b0, 32'h0,         1'b1, 32'h2, 32'h2};
    vecs[2] = '{32'h0000_1007, 1'b0, 32'h0,         1'b1, 32'h2, 32'h2};
    vecs[3] = '{32'h0000_1003, 1'b0, 32'h0,         1'b1, 32'h0, 32'h2};
    vecs[4] = '{32'h0000_2000, 1'b1, 32'hA5,        1'b0, 32'h0, 32'h2};
    vecs[5] = '{32'h0000_1008, 1'b1, 32'h55,        1'b0, 32'h0, 32'h2};
    vecs[6] = '{32'h0000_0FFC, 1'b1, 32'h33,        1'b0, 32'h0, 32'h2};
    vecs[7] = '{32'h0000_1004, 1'b1, 32'hFFFF_FFFB, 1'b1, 32'h2, 32'h2};
    vecs[8] = '{32'h0000_1006, 1'b0, 32'h0,         1'b1, 32'h2, 32'h2};
    vecs[9] = '{32'h9000_1000, 1'b1, 32'h11,        1'b0, 32'h0, 32'h2};

    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    a   = STAT;
    #1 check("reset_status", rd, 32'h2);

    // Register decode vectors; none of them may queue a byte.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a  = vecs[i].a;
      we = vecs[i].we;
      wd = vecs[i].wd;
      #1;
      check("vec_hit", 32'(hit), 32'(vecs[i].exp_hit));
      check("vec_rd", rd, vecs[i].exp_rd);
      @(negedge clk);
      we = 1'b0;
      a  = STAT;
      #1;
      check("vec_tx_idle", 32'(tx), 32'd1);
      check("vec_busy", 32'(busy), 32'd0);
      check("vec_status", rd, vecs[i].exp_stat);
    end

    // Single frame, checked cycle by cycle.
    @(negedge clk);
    a  = BASE;
    wd = 32'hA5;
    we = 1'b1;
    sb_q.push_back(8'hA5);
    byte_v = 8'hA5;
    @(posedge clk);
    for (int n = 0; n <= 41; n++) begin
      @(negedge clk);
      we = 1'b0;
      if (n == 0)       exp_v = 32'd1;
      else if (n <= 4)  exp_v = 32'd0;
      else if (n <= 36) exp_v = 32'(byte_v[3'((n - 5) / 4)]);
      else              exp_v = 32'd1;
      check("a5_tx", 32'(tx), exp_v);
      if (n == 40) check("a5_busy_end", 32'(busy), 32'd1);
      if (n == 41) check("a5_busy_idle", 32'(busy), 32'd0);
    end

    // Overflow while a frame is running.
    start_q.delete();
    @(negedge clk);
    a  = BASE;
    wd = 32'h5A;
    we = 1'b1;
    sb_q.push_back(8'h5A);
    @(negedge clk);
    we = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      a  = BASE;
      wd = 32'(k);
      we = 1'b1;
      if (k <= 4) sb_q.push_back(8'(k));
      @(negedge clk);
    end
    we = 1'b0;
    a  = STAT;
    #1 check("ovf_status", rd, 32'h4D);
    @(negedge clk);
    #1 check("ovf_sticky", rd, 32'h4D);
    @(negedge clk);
    a  = STAT;
    wd = 32'h4;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1 check("ovf_clear", rd, 32'h49);

    // Push into the full FIFO on the edge that pops the head.
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      #1;
      if (rd[3] == 1'b0) found = 1'b1;
    end
    check("idle_seen", 32'(found), 32'd1);
    if (found) begin
      a  = BASE;
      wd = 32'h06;
      we = 1'b1;
      sb_q.push_back(8'h06);
      @(negedge clk);
      we = 1'b0;
      a  = STAT;
      #1 check("pop_push_status", rd, 32'h49);
    end

    for (int t = 0; t < 500 && busy; t++) @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("frame_count", 32'(start_q.size()), 32'd6);
    for (int i = 1; i < start_q.size(); i++) begin
      check("frame_gap", 32'(start_q[i] - start_q[i - 1]), 32'(10 * C + 1));
    end
    a = STAT;
    #1 check("drain_status", rd, 32'h2);

    // Reset in the middle of data bit 3 with two bytes queued.
    @(negedge clk);
    a  = BASE;
    wd = 32'h11;
    we = 1'b1;
    @(negedge clk);
    wd = 32'h22;
    @(negedge clk);
    wd = 32'h33;
    @(negedge clk);
    we = 1'b0;
    a  = STAT;
    repeat (16) @(negedge clk);
    #1;
    check("pre_rst_tx", 32'(tx), 32'd0);
    check("pre_rst_status", rd, 32'h28);
    rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", rd, 32'h2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_status", rd, 32'h2);
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("no_frame_after_rst", 32'(saw_low), 32'd0);

    // First push lands on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a   = BASE;
    wd  = 32'h3C;
    we  = 1'b1;
    sb_q.push_back(8'h3C);
    @(negedge clk);
    we = 1'b0;
    a  = STAT;
    #1 check("first_push_status", rd, 32'h10);

    for (int t = 0; t < 200 && busy; t++) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_tx", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
